// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one main-memory bus between the instruction and
// data ports of CPUS cores, one transaction at a time, with a timeout watchdog.
module memory_arbiter #(
    parameter int CPUS    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [CPUS-1:0]       iREN,
    input  logic [CPUS-1:0][31:0] iaddr,
    input  logic [CPUS-1:0]       dREN,
    input  logic [CPUS-1:0]       dWEN,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    output logic [CPUS-1:0]       iwait,
    output logic [CPUS-1:0]       dwait,
    output logic [CPUS-1:0][31:0] iload,
    output logic [CPUS-1:0][31:0] dload,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic [31:0]           ramload,
    input  logic                  ramready,
    output logic                  bus_err
);

    localparam int              CW         = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [7:0]      TIMEOUT_C  = 8'(TIMEOUT);
    localparam logic [31:0]     ABORT_WORD = 32'hBAD1_BAD1;
    localparam logic [CW-1:0]   LAST_RST   = CW'(CPUS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        TY_I  = 2'd0,
        TY_DR = 2'd1,
        TY_DW = 2'd2
    } acc_t;

    state_t        state_q,   state_d;
    logic [CW-1:0] winner_q,  winner_d;
    acc_t          type_q,    type_d;
    logic [31:0]   addr_q,    addr_d;
    logic [31:0]   store_q,   store_d;
    logic [31:0]   load_q,    load_d;
    logic [CW-1:0] last_q,    last_d;
    logic [7:0]    cnt_q,     cnt_d;
    logic          bus_err_q, bus_err_d;

    logic [CPUS-1:0] req_any_s;
    logic            grant_found_s;
    logic [CW-1:0]   grant_core_s;
    logic [CW-1:0]   scan_idx_s;
    int              scan_sum_s;
    acc_t            grant_type_s;
    logic [31:0]     grant_addr_s;

    assign req_any_s = iREN | dREN | dWEN;

    // Round-robin scan starting one past the previous winner
    always_comb begin
        grant_found_s = 1'b0;
        grant_core_s  = '0;
        scan_idx_s    = '0;
        scan_sum_s    = 0;
        for (int i = 1; i <= CPUS; i++) begin
            scan_sum_s    = int'(last_q) + i;
            scan_sum_s    = (scan_sum_s >= CPUS) ? (scan_sum_s - CPUS) : scan_sum_s;
            scan_idx_s    = CW'(scan_sum_s);
            grant_core_s  = (!grant_found_s && req_any_s[scan_idx_s]) ? scan_idx_s : grant_core_s;
            grant_found_s = grant_found_s | req_any_s[scan_idx_s];
        end
    end

    // Fixed priority inside the winning core: write, data read, fetch
    always_comb begin
        grant_type_s = TY_I;
        grant_addr_s = iaddr[grant_core_s];
        if (dWEN[grant_core_s]) begin
            grant_type_s = TY_DW;
            grant_addr_s = daddr[grant_core_s];
        end else if (dREN[grant_core_s]) begin
            grant_type_s = TY_DR;
            grant_addr_s = daddr[grant_core_s];
        end else begin
            grant_type_s = TY_I;
            grant_addr_s = iaddr[grant_core_s];
        end
    end

    // Transaction FSM: next state, latches, watchdog
    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        type_d    = type_q;
        addr_d    = addr_q;
        store_d   = store_q;
        load_d    = load_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        bus_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    state_d  = ST_ACCESS;
                    winner_d = grant_core_s;
                    type_d   = grant_type_s;
                    addr_d   = grant_addr_s;
                    store_d  = dstore[grant_core_s];
                    cnt_d    = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (ramready) begin
                    state_d = ST_DONE;
                    load_d  = (type_q == TY_DW) ? load_q : ramload;
                end else if (cnt_q == TIMEOUT_C) begin
                    // Dead RAM: complete with a recognisable poison word
                    state_d   = ST_DONE;
                    load_d    = ABORT_WORD;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                last_d  = winner_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latch registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= ST_IDLE;
            winner_q  <= '0;
            type_q    <= TY_I;
            addr_q    <= 32'h0000_0000;
            store_q   <= 32'h0000_0000;
            load_q    <= 32'h0000_0000;
            last_q    <= LAST_RST;
            cnt_q     <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            type_q    <= type_d;
            addr_q    <= addr_d;
            store_q   <= store_d;
            load_q    <= load_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign ramREN   = (state_q == ST_ACCESS) && (type_q != TY_DW);
    assign ramWEN   = (state_q == ST_ACCESS) && (type_q == TY_DW);
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign bus_err  = bus_err_q;

    // Per-core wait lines drop only for the winner during DONE
    always_comb begin
        iwait = '0;
        dwait = '0;
        iload = '0;
        dload = '0;
        for (int c = 0; c < CPUS; c++) begin
            iwait[c] = iREN[c] & ~((state_q == ST_DONE) && (winner_q == CW'(c)) && (type_q == TY_I));
            dwait[c] = (dREN[c] | dWEN[c]) &
                       ~((state_q == ST_DONE) && (winner_q == CW'(c)) && (type_q != TY_I));
            iload[c] = load_q;
            dload[c] = load_q;
        end
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the single-ported main-memory bus between the instruction and data ports of CPUS cores, one transaction at a time. It sits between the per-core cache/datapath memory ports and the RAM controller. Arbitration is round-robin across cores, with fixed priority inside a core: write, then data read, then instruction fetch. A timeout watchdog keeps a dead RAM from hanging the processor.

## Interface
- CPUS, default 2: number of cores; core index width CW = $clog2(CPUS), minimum 1.
- TIMEOUT, default 255: maximum ACCESS cycles before abort; counter width 8 bits.
- CLK  in  1: clock, rising edge.
- nRST  in  1: reset, asynchronous, active-low.
- iREN  in  [CPUS]: instruction fetch request per core.
- iaddr  in  [CPUS] x 32: fetch address per core.
- dREN  in  [CPUS]: data read request per core.
- dWEN  in  [CPUS]: data write request per core.
- daddr  in  [CPUS] x 32: data address per core.
- dstore  in  [CPUS] x 32: write data per core.
- iwait  out  [CPUS]: fetch not complete. Low for one cycle means iload is valid.
- dwait  out  [CPUS]: data op not complete. Low for one cycle means done, and dload is valid on a read.
- iload  out  [CPUS] x 32: fetched word.
- dload  out  [CPUS] x 32: loaded word.
- ramREN  out  1: RAM read strobe.
- ramWEN  out  1: RAM write strobe.
- ramaddr  out  32: RAM address.
- ramstore  out  32: RAM write data.
- ramload  in  32: RAM read data, valid when ramready=1.
- ramready  in  1: RAM completes the current access this cycle.
- bus_err  out  1: one-cycle pulse when an access times out.

## Operation
- Registered state: FSM, latched winner core (CW bits), latched type (I, DR, DW), latched address and store data, load register, round-robin pointer `last`, and timeout counter.
- FSM states are IDLE, ACCESS and DONE.
- **IDLE:**
  - Scan cores starting at (last+1) mod CPUS. The first core with any request wins.
  - Within the winning core, choose dWEN, then dREN, then iREN. When dWEN and dREN are both high, the access is a write.
  - Latch the winner, type, address (daddr for data, iaddr for fetch) and dstore. Clear the counter and go to ACCESS.
  - With no requests, stay in IDLE.
- **ACCESS:**
  - Drive ramREN=1 for I or DR, or ramWEN=1 for DW. Drive ramaddr and ramstore from the latches.
  - ramready=1: capture ramload into the load register (reads only) and go to DONE.
  - Otherwise increment the counter. When the counter equals TIMEOUT, load 32'hBAD1BAD1, pulse bus_err and go to DONE.
- **DONE:**
  - RAM strobes are 0. Assert completion for the winner only. Set last = winner and go to IDLE.
- Outputs:
  - iwait[c] = iREN[c] & ~(state==DONE & winner==c & type==I).
  - dwait[c] = (dREN[c] | dWEN[c]) & ~(state==DONE & winner==c & type!=I).
  - iload and dload for every core are driven from the single load register. They are only meaningful during that core's completion cycle.
- Requesters hold request, address and data until their wait drops. If a requester withdraws mid-ACCESS, the access still finishes and the DONE cycle is consumed, with no completion seen.
- An address change during ACCESS has no effect, because the address is latched.

## Timing
- Reset values:
  - state=IDLE, winner=0, type=I, last=CPUS-1 (core 0 has first priority), counter=0, load=0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, bus_err=0.
  - iwait and dwait follow their requests, which are combinational.
- Reset asserted mid-ACCESS drops the RAM strobes immediately, regardless of CLK.
- Latency:
  - Request seen in IDLE at cycle 0. ACCESS runs from cycle 1. With ramready at cycle k≥1, DONE (wait low) occurs at cycle k+1.
  - The minimum is 2 cycles from request to completion.
- Back-to-back transactions pass through one IDLE cycle each, giving a minimum of 3 cycles per transaction.
- Timeout: with ramready never asserted, the ACCESS cycle with counter==TIMEOUT is the last. DONE follows, which makes TIMEOUT+1 ACCESS cycles.
- Fairness: with all cores requesting continuously, grants rotate 0,1,…,CPUS-1,0. No core waits more than CPUS transactions.
- Within a core, a pending fetch can be starved by continuous data traffic from that core. This is intended, because data accesses stall the pipeline.

## Test plan
- Reset with iREN[0]=1, iaddr[0]=0x40, ramready rising on the first ACCESS cycle and ramload=0x00A00093:
  - ramREN=1 and ramaddr=0x40 at cycle 1.
  - iwait[0]=0 and iload[0]=0x00A00093 at cycle 2.
- Core 0 with dWEN=1, daddr=0x80, dstore=0xDEADBEEF, plus iREN=1 at the same time:
  - The write is granted first: ramWEN=1, ramstore=0xDEADBEEF.
  - The fetch is granted only after the write's DONE and the following IDLE.
- Both cores continuously requesting fetches, with ramready=1 on every cycle:
  - Grants alternate 0,1,0,1, each core completing every 6 cycles.
  - Core 0 is granted first after reset.
- dREN[1]=1 with ramready held 0:
  - bus_err pulses after TIMEOUT+1 ACCESS cycles.
  - dwait[1]=0 with dload[1]=0xBAD1BAD1.
- nRST dropped while in ACCESS with ramREN=1:
  - ramREN=0 at once and the state is IDLE.
  - After reset is released, the still-held request is re-arbitrated from core 0.
- iREN[0] withdrawn mid-ACCESS:
  - The access completes and the DONE cycle passes with no iwait change.
  - The next IDLE grants core 1's pending dREN.
